// File: rtl/battleship_turn_controller.sv
// -----------------------------------------------------------------------------
// battleship_turn_controller
//
// Game sequencer for Battleship. It owns the single shot port into the player
// and PC boards, alternates turns, enforces the per-turn time limit for the
// player, draws PC targets from the PRNG, tallies hits and declares a winner.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   start                    pulse: leave IDLE/WIN/LOSE and begin placement
//   place_done               level: ships placed on both boards
//   ships_total[2:0]         hits needed to win (0 treated as 1), latched on start
//   player_fire, player_row, player_col   player shot request
//   rand_row, rand_col       PRNG coordinates, new every clk
//   shot_done, shot_hit, shot_repeat      board response (hit/repeat valid with done)
//   shot_valid, shot_target, shot_row, shot_col   shot request to the boards
//                            (target 0 = PC board, 1 = player board)
//   state[2:0]               current game state (encoding below)
//   time_left[TIMER_W-1:0]   cycles remaining in the player turn
//   player_hits, pc_hits     saturating hit tallies
//
// Build option
//   BTL_AUTO_PLAY_EN  when defined, a player timeout fires an automatic shot at
//                     the current PRNG coordinates instead of forfeiting the turn.
//
// state | meaning
// ------+----------------------------------------------------------
// 0     | IDLE    - waiting for start
// 1     | PLACE   - ships being placed, waiting for place_done
// 2     | P_TURN  - player turn, timer counting down
// 3     | P_WAIT  - player shot in flight, timer frozen
// 4     | PC_TURN - one cycle: draw PC target from the PRNG
// 5     | PC_WAIT - PC shot in flight
// 6     | WIN     - player sank the required ships (terminal)
// 7     | LOSE    - PC sank the required ships (terminal)
// -----------------------------------------------------------------------------
module battleship_turn_controller #(
  parameter int BOARD_N     = 5,
  parameter int TURN_CYCLES = 750_000_000,
  parameter int TIMER_W     = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               place_done,
  input  logic [2:0]         ships_total,
  input  logic               player_fire,
  input  logic [2:0]         player_row,
  input  logic [2:0]         player_col,
  input  logic [2:0]         rand_row,
  input  logic [2:0]         rand_col,
  input  logic               shot_done,
  input  logic               shot_hit,
  input  logic               shot_repeat,
  output logic               shot_valid,
  output logic               shot_target,
  output logic [2:0]         shot_row,
  output logic [2:0]         shot_col,
  output logic [2:0]         state,
  output logic [TIMER_W-1:0] time_left,
  output logic [2:0]         player_hits,
  output logic [2:0]         pc_hits
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PLACE   = 3'd1;
  localparam logic [2:0] S_P_TURN  = 3'd2;
  localparam logic [2:0] S_P_WAIT  = 3'd3;
  localparam logic [2:0] S_PC_TURN = 3'd4;
  localparam logic [2:0] S_PC_WAIT = 3'd5;
  localparam logic [2:0] S_WIN     = 3'd6;
  localparam logic [2:0] S_LOSE    = 3'd7;

  localparam logic [TIMER_W-1:0] TURN_LOAD = TIMER_W'(TURN_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

  logic [2:0] ships_goal;
  logic [2:0] ph_next;
  logic [2:0] pc_next;
  logic       player_in_range;

`ifdef BTL_AUTO_PLAY_EN
  logic auto_shot;   // current player shot was issued by the timeout
  logic auto_retry;  // auto shot hit a used cell; reissue next cycle
`endif

  function automatic logic coord_ok(input logic [2:0] v);
    return int'(v) < BOARD_N;
  endfunction

  // PRNG values beyond the board are folded back once by subtracting BOARD_N.
  function automatic logic [2:0] fold(input logic [2:0] v);
    if (int'(v) >= BOARD_N) return 3'(int'(v) - BOARD_N);
    else                    return v;
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] c, input logic hit);
    if (hit && (c != 3'd7)) return c + 3'd1;
    else                    return c;
  endfunction

  always_comb begin
    ph_next         = sat_inc(player_hits, shot_hit);
    pc_next         = sat_inc(pc_hits, shot_hit);
    player_in_range = coord_ok(player_row) && coord_ok(player_col);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      shot_valid  <= 1'b0;
      shot_target <= 1'b0;
      shot_row    <= 3'd0;
      shot_col    <= 3'd0;
      time_left   <= '0;
      player_hits <= 3'd0;
      pc_hits     <= 3'd0;
      ships_goal  <= 3'd1;
`ifdef BTL_AUTO_PLAY_EN
      auto_shot   <= 1'b0;
      auto_retry  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          shot_valid <= 1'b0;
          if (start) begin
            ships_goal  <= (ships_total == 3'd0) ? 3'd1 : ships_total;
            player_hits <= 3'd0;
            pc_hits     <= 3'd0;
            state       <= S_PLACE;
          end
        end

        S_PLACE: begin
          if (place_done) begin
            time_left <= TURN_LOAD;
            state     <= S_P_TURN;
          end
        end

        S_P_TURN: begin
          // A valid fire takes priority over a timeout in the same cycle, and
          // the fire cycle itself does not consume timer budget.
          if (player_fire && player_in_range) begin
            shot_row    <= player_row;
            shot_col    <= player_col;
            shot_target <= 1'b0;
            shot_valid  <= 1'b1;
            state       <= S_P_WAIT;
`ifdef BTL_AUTO_PLAY_EN
            auto_shot   <= 1'b0;
`endif
          end else if (time_left <= TIMER_ONE) begin
            time_left <= '0;
`ifdef BTL_AUTO_PLAY_EN
            shot_row    <= fold(rand_row);
            shot_col    <= fold(rand_col);
            shot_target <= 1'b0;
            shot_valid  <= 1'b1;
            auto_shot   <= 1'b1;
            state       <= S_P_WAIT;
`else
            state     <= S_PC_TURN;
`endif
          end else begin
            time_left <= time_left - TIMER_ONE;
          end
        end

        S_P_WAIT: begin
`ifdef BTL_AUTO_PLAY_EN
          if (auto_retry) begin
            shot_row   <= fold(rand_row);
            shot_col   <= fold(rand_col);
            shot_valid <= 1'b1;
            auto_retry <= 1'b0;
          end else
`endif
          if (shot_valid && shot_done) begin
            shot_valid <= 1'b0;
            if (shot_repeat) begin
`ifdef BTL_AUTO_PLAY_EN
              if (auto_shot) auto_retry <= 1'b1;
              else           state      <= S_P_TURN;
`else
              state <= S_P_TURN;
`endif
            end else begin
              player_hits <= ph_next;
              state       <= (ph_next == ships_goal) ? S_WIN : S_PC_TURN;
            end
          end
        end

        S_PC_TURN: begin
          shot_row    <= fold(rand_row);
          shot_col    <= fold(rand_col);
          shot_target <= 1'b1;
          shot_valid  <= 1'b1;
          state       <= S_PC_WAIT;
        end

        S_PC_WAIT: begin
          if (shot_valid && shot_done) begin
            shot_valid <= 1'b0;
            if (shot_repeat) begin
              state <= S_PC_TURN;
            end else begin
              pc_hits <= pc_next;
              if (pc_next == ships_goal) begin
                state <= S_LOSE;
              end else begin
                time_left <= TURN_LOAD;
                state     <= S_P_TURN;
              end
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
